// File: rtl/fir_decim_buffer_if.sv
// fir_decim_buffer_if
//   Bundles the sample input, the FWFT read handshake and the status outputs
//   of fir_decim_buffer.
//   master: the filter/consumer side. It drives in_data, in_valid and out_ready.
//   slave : the buffer. It drives out_data, out_valid, level, overflow and run.
//   Handshake: a sample is accepted on every rising edge with in_valid=1.
//   There is no backpressure toward the filter. A FIFO word transfers on
//   every rising edge with out_valid=1 and out_ready=1. out_ready is ignored
//   while out_valid=0.
//   run is a debug view of the FSM: 0 = warm-up, 1 = run.
interface fir_decim_buffer_if #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] in_data;   // signed Q5.6, stored bit-exact
   logic              in_valid;
   logic [DATA_W-1:0] out_data;  // signed Q5.6, 0 when out_valid=0
   logic              out_valid;
   logic              out_ready;
   logic [LVL_W-1:0]  level;
   logic              overflow;
   logic              run;

   modport master (
      output in_data, in_valid, out_ready,
      input  out_data, out_valid, level, overflow, run
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output out_data, out_valid, level, overflow, run
   );
endinterface

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer
//   Sits after the 8-tap Q5.6 FIR. It drops the first WARMUP accepted
//   samples, which are the filter fill transient. It then keeps one of every
//   DECIM accepted samples and queues the kept samples in a DEPTH-entry
//   first-word-fall-through FIFO.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset. It flushes the FIFO and restarts
//          warm-up.
//     bus  fir_decim_buffer_if.slave. It carries the sample input, the FWFT
//          read handshake, level, sticky overflow and the run debug flag.
module fir_decim_buffer #(
   parameter int DATA_W = 12,
   parameter int DECIM  = 4,
   parameter int WARMUP = 8,
   parameter int DEPTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   fir_decim_buffer_if.slave    bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

   typedef enum logic {
      S_WARMUP = 1'b0,
      S_RUN    = 1'b1
   } state_t;

   // With no warm-up requested, the buffer comes out of reset already running.
   localparam state_t RESET_STATE = (WARMUP == 0) ? S_RUN : S_WARMUP;

   state_t            state, state_next;
   logic [WCNT_W-1:0] warm_cnt, warm_cnt_next;
   logic [PH_W-1:0]   phase, phase_next;
   logic              keep;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level_q, level_next;
   logic              out_valid_q;
   logic              overflow_q;
   logic              full, push, pop;

   // ---------------- warm-up / decimation FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RESET_STATE;
         warm_cnt <= '0;
         phase    <= '0;
      end else begin
         state    <= state_next;
         warm_cnt <= warm_cnt_next;
         phase    <= phase_next;
      end
   end

   always_comb begin
      state_next    = state;
      warm_cnt_next = warm_cnt;
      phase_next    = phase;
      keep          = 1'b0;
      case (state)
         S_WARMUP: begin
            if (bus.in_valid) begin
               if (warm_cnt == WARM_LAST) begin
                  // The last discarded sample. RUN starts with phase still at 0.
                  state_next    = S_RUN;
                  warm_cnt_next = '0;
               end else begin
                  warm_cnt_next = warm_cnt + 1'b1;
               end
            end
         end
         S_RUN: begin
            if (bus.in_valid) begin
               keep       = (phase == '0);
               phase_next = (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
         end
         default: state_next = RESET_STATE;
      endcase
   end

   // ---------------- FWFT FIFO ----------------
   assign full = (level_q == LVL_FULL);
   assign pop  = out_valid_q && bus.out_ready;
   // When the FIFO is full, a pop in the same cycle frees the slot that this
   // push uses.
   assign push = keep && (!full || pop);

   always_comb begin
      level_next = level_q;
      case ({push, pop})
         2'b10:   level_next = level_q + 1'b1;
         2'b01:   level_next = level_q - 1'b1;
         default: level_next = level_q;
      endcase
   end

   // The storage array has no reset. Clearing the pointers and level is
   // enough to flush it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level_q     <= level_next;
         out_valid_q <= (level_next != '0);
         if (keep && full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign bus.out_data  = out_valid_q ? mem[rd_ptr] : '0;
   assign bus.out_valid = out_valid_q;
   assign bus.level     = level_q;
   assign bus.overflow  = overflow_q;
   assign bus.run       = (state == S_RUN);
endmodule
